// File: rtl/priority_mux_pkg.sv
// Shared types and helpers for the priority arbitration mux.
// Latency: none (pure functions and types).
// Backpressure: not applicable.
package priority_mux_pkg;

  typedef enum logic {
    MODE_STRICT = 1'b0,
    MODE_AGING  = 1'b1
  } mode_e;

  // Widest priority field the helpers handle; callers truncate to their width.
  localparam int PRIO_MAX_W = 16;

  function automatic logic [PRIO_MAX_W-1:0] eff_prio(
    input logic [PRIO_MAX_W-1:0] prio,
    input logic                  aged,
    input mode_e                 mode,
    input int                    pw
  );
    logic [PRIO_MAX_W-1:0] ones;
    ones = '0;
    for (int b = 0; b < PRIO_MAX_W; b++) begin
      if (b < pw) ones[b] = 1'b1;
    end
    return (mode == MODE_AGING && aged) ? ones : prio;
  endfunction

  // (base + offset) mod n, valid for base < n and offset <= n.
  function automatic int unsigned rr_index(
    input int unsigned base,
    input int unsigned offset,
    input int unsigned n
  );
    int unsigned idx;
    idx = base + offset;
    if (idx >= n) idx = idx - n;
    return idx;
  endfunction

endpackage

// File: rtl/priority_pick.sv
// Picks the highest effective-priority valid channel, ties round-robin after last_grant.
// Latency: combinational.
// Backpressure: none; the caller gates the grant.
module priority_pick
  import priority_mux_pkg::*;
#(
  parameter int N_SIGNALS        = 4,
  parameter int N_PRIORITY_WIDTH = 2,
  parameter int SEL_WIDTH        = $clog2(N_SIGNALS)
) (
  input  logic [N_SIGNALS-1:0]                  valid,
  input  logic [N_SIGNALS*N_PRIORITY_WIDTH-1:0] eff,
  input  logic [SEL_WIDTH-1:0]                  last_grant,
  output logic [SEL_WIDTH-1:0]                  pick,
  output logic                                  any_valid
);

  logic                        found;
  logic [N_PRIORITY_WIDTH-1:0] best;
  int unsigned                 idx;

  // Search order starts just after last_grant; strict '>' keeps the first
  // channel found among equals, which is the round-robin tie-break.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    best  = '0;
    idx   = 0;
    for (int unsigned k = 1; k <= N_SIGNALS; k++) begin
      idx = rr_index(32'(last_grant), k, N_SIGNALS);
      if (valid[idx] && (!found || eff[idx*N_PRIORITY_WIDTH +: N_PRIORITY_WIDTH] > best)) begin
        found = 1'b1;
        best  = eff[idx*N_PRIORITY_WIDTH +: N_PRIORITY_WIDTH];
        pick  = SEL_WIDTH'(idx);
      end
    end
    any_valid = found;
  end

endmodule

// File: rtl/priority_arb_mux.sv
// N-channel priority mux with round-robin tie-break and optional starvation aging.
// Latency: 1 cycle from input accept to out_valid; 1 word/cycle throughput.
// Backpressure: out_valid & !out_ready holds the output register and drops all in_ready.
module priority_arb_mux
  import priority_mux_pkg::*;
#(
  parameter int N_SIGNALS        = 4,
  parameter int N_SIGNAL_WIDTH   = 8,
  parameter int N_PRIORITY_WIDTH = 2,
  parameter int AGE_WIDTH        = 4,
  parameter int AGE_THRESHOLD    = 15,
  parameter int SEL_WIDTH        = $clog2(N_SIGNALS)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  mode,
  input  logic [N_SIGNALS-1:0]                  in_valid,
  input  logic [N_SIGNALS*N_SIGNAL_WIDTH-1:0]   in_data,
  input  logic [N_SIGNALS*N_PRIORITY_WIDTH-1:0] in_priority,
  output logic [N_SIGNALS-1:0]                  in_ready,
  output logic                                  out_valid,
  output logic [N_SIGNAL_WIDTH-1:0]             out_data,
  output logic [SEL_WIDTH-1:0]                  out_sel,
  output logic [N_PRIORITY_WIDTH-1:0]           out_priority,
  input  logic                                  out_ready
);

  localparam logic [AGE_WIDTH-1:0] AGE_MAX = AGE_WIDTH'(AGE_THRESHOLD);

  logic                                  load_en;
  logic                                  any_valid;
  logic                                  accept;
  logic [SEL_WIDTH-1:0]                  pick;
  logic [SEL_WIDTH-1:0]                  last_grant;
  logic [N_SIGNALS*N_PRIORITY_WIDTH-1:0] eff;
  logic [AGE_WIDTH-1:0]                  age [N_SIGNALS];
  logic [N_SIGNAL_WIDTH-1:0]             pick_data;
  logic [N_PRIORITY_WIDTH-1:0]           pick_prio;

  always_comb begin
    eff = '0;
    for (int i = 0; i < N_SIGNALS; i++) begin
      eff[i*N_PRIORITY_WIDTH +: N_PRIORITY_WIDTH] = N_PRIORITY_WIDTH'(
        eff_prio(PRIO_MAX_W'(in_priority[i*N_PRIORITY_WIDTH +: N_PRIORITY_WIDTH]),
                 age[i] == AGE_MAX, mode_e'(mode), N_PRIORITY_WIDTH));
    end
  end

  priority_pick #(
    .N_SIGNALS        (N_SIGNALS),
    .N_PRIORITY_WIDTH (N_PRIORITY_WIDTH),
    .SEL_WIDTH        (SEL_WIDTH)
  ) u_pick (
    .valid      (in_valid),
    .eff        (eff),
    .last_grant (last_grant),
    .pick       (pick),
    .any_valid  (any_valid)
  );

  assign load_en = !out_valid || out_ready;
  assign accept  = load_en && any_valid && !rst;

  // in_data only feeds the register input, never in_ready.
  always_comb begin
    in_ready  = '0;
    pick_data = '0;
    pick_prio = '0;
    for (int i = 0; i < N_SIGNALS; i++) begin
      if (SEL_WIDTH'(i) == pick) begin
        in_ready[i] = accept;
        pick_data   = in_data[i*N_SIGNAL_WIDTH +: N_SIGNAL_WIDTH];
        pick_prio   = eff[i*N_PRIORITY_WIDTH +: N_PRIORITY_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_sel      <= '0;
      out_priority <= '0;
      last_grant   <= SEL_WIDTH'(N_SIGNALS - 1);
      for (int i = 0; i < N_SIGNALS; i++) age[i] <= '0;
    end else begin
      if (accept) begin
        out_valid    <= 1'b1;
        out_data     <= pick_data;
        out_sel      <= pick;
        out_priority <= pick_prio;
        last_grant   <= pick;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      // Ages keep counting through output stalls.
      for (int i = 0; i < N_SIGNALS; i++) begin
        if (!in_valid[i] || (accept && pick == SEL_WIDTH'(i)) || mode == MODE_STRICT)
          age[i] <= '0;
        else if (age[i] < AGE_MAX)
          age[i] <= age[i] + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_priority_arb_mux.sv
// Directed bench for priority_arb_mux: driver pushes expected words, negedge monitor pops and compares.
module tb_priority_arb_mux;

  typedef struct packed {
    logic [1:0] sel;
    logic [7:0] data;
    logic [1:0] prio;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        mode;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [7:0]  in_priority;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_sel;
  logic [1:0]  out_priority;
  logic        out_ready;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  localparam logic [7:0] P_STRICT = 8'b01_11_10_00;  // ch3:1 ch2:3 ch1:2 ch0:0
  localparam logic [7:0] P_TIE    = 8'b10_10_10_10;
  localparam logic [7:0] P_AGE    = 8'b11_00_00_00;  // ch3:3 ch0:0

  priority_arb_mux #(
    .N_SIGNALS        (4),
    .N_SIGNAL_WIDTH   (8),
    .N_PRIORITY_WIDTH (2),
    .AGE_WIDTH        (4),
    .AGE_THRESHOLD    (3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .mode         (mode),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_priority  (in_priority),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_sel      (out_sel),
    .out_priority (out_priority),
    .out_ready    (out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Drives one cycle of inputs; checks in_ready and queues the expected word.
  task automatic step(input logic [3:0] v, input logic [7:0] pr, input logic ordy,
                      input logic md, input logic [7:0] base, input logic [3:0] exp_rdy,
                      input logic [1:0] exp_p);
    exp_t e;
    @(posedge clk); #1;
    in_valid    = v;
    in_priority = pr;
    out_ready   = ordy;
    mode        = md;
    for (int i = 0; i < 4; i++) in_data[i*8 +: 8] = base + 8'(i);
    @(negedge clk);
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    if (exp_rdy != 4'b0000) begin
      e = '0;
      for (int i = 0; i < 4; i++) if (exp_rdy[i]) e.sel = 2'(i);
      e.data = base + 8'(e.sel);
      e.prio = exp_p;
      sb.push_back(e);
    end
  endtask

  task automatic reset_dut();
    @(posedge clk); #1;
    rst         = 1'b1;
    in_valid    = 4'b1111;
    in_priority = P_TIE;
    out_ready   = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    @(posedge clk); #1;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data", 32'(out_data), 32'h0);
    chk("rst_out_sel", 32'(out_sel), 32'h0);
    chk("rst_out_prio", 32'(out_priority), 32'h0);
    sb.delete();
    rst      = 1'b0;
    in_valid = 4'b0000;
  endtask

  // Monitor: every output handshake must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_unexpected: got sel %0d data %0h, expected no word", out_sel, out_data);
        end else begin
          e = sb.pop_front();
          chk("out_data", 32'(out_data), 32'(e.data));
          chk("out_sel", 32'(out_sel), 32'(e.sel));
          chk("out_priority", 32'(out_priority), 32'(e.prio));
        end
      end
    end
  end

  initial begin
    rst = 1'b1; mode = 1'b0; in_valid = '0; in_data = '0; in_priority = '0; out_ready = 1'b0;
    reset_dut();

    // Round-robin among equal priorities from reset: 0,1,2,3,0 with no bubbles.
    step(4'b1111, P_TIE, 1'b1, 1'b0, 8'hA0, 4'b0001, 2'd2);
    for (int k = 1; k < 5; k++) begin
      step(4'b1111, P_TIE, 1'b1, 1'b0, 8'hA0, 4'b0001 << (k % 4), 2'd2);
      chk("rr_no_bubble", 32'(out_valid), 32'h1);
    end
    step(4'b0000, P_TIE, 1'b1, 1'b0, 8'hA0, 4'b0000, 2'd0);
    step(4'b0000, P_TIE, 1'b1, 1'b0, 8'hA0, 4'b0000, 2'd0);
    chk("idle_out_valid", 32'(out_valid), 32'h0);

    // Strict pick: ch2 has the highest priority.
    step(4'b1111, P_STRICT, 1'b1, 1'b0, 8'hA0, 4'b0100, 2'd3);
    step(4'b0000, P_STRICT, 1'b1, 1'b0, 8'hA0, 4'b0000, 2'd0);
    step(4'b0000, P_STRICT, 1'b1, 1'b0, 8'hA0, 4'b0000, 2'd0);
    chk("idle_out_valid", 32'(out_valid), 32'h0);

    // Backpressure: 5 stalled cycles, then drain and reload on one edge.
    step(4'b1111, P_STRICT, 1'b1, 1'b0, 8'hB0, 4'b0100, 2'd3);
    for (int k = 0; k < 5; k++) begin
      step(4'b1111, P_STRICT, 1'b0, 1'b0, 8'hB0, 4'b0000, 2'd0);
      chk("stall_valid", 32'(out_valid), 32'h1);
      chk("stall_data", 32'(out_data), 32'hB2);
      chk("stall_sel", 32'(out_sel), 32'h2);
    end
    step(4'b1111, P_STRICT, 1'b1, 1'b0, 8'hC0, 4'b0100, 2'd3);
    step(4'b0000, P_STRICT, 1'b1, 1'b0, 8'hC0, 4'b0000, 2'd0);
    chk("reload_valid", 32'(out_valid), 32'h1);
    step(4'b0000, P_STRICT, 1'b1, 1'b0, 8'hC0, 4'b0000, 2'd0);
    chk("idle_out_valid", 32'(out_valid), 32'h0);

    // Aging: ch0 boosted to 3 after waiting 3 cycles, wins tie after ch3.
    for (int k = 0; k < 8; k++)
      step(4'b1001, P_AGE, 1'b1, 1'b1, 8'hD0, (k % 4 == 3) ? 4'b0001 : 4'b1000, 2'd3);
    // Same stimulus in strict mode: ch0 starves.
    for (int k = 0; k < 8; k++)
      step(4'b1001, P_AGE, 1'b1, 1'b0, 8'hD0, 4'b1000, 2'd3);
    step(4'b0000, P_AGE, 1'b1, 1'b0, 8'hD0, 4'b0000, 2'd0);
    step(4'b0000, P_AGE, 1'b1, 1'b0, 8'hD0, 4'b0000, 2'd0);
    chk("idle_out_valid", 32'(out_valid), 32'h0);

    // Reset while a word is stalled: word discarded, first tie goes to ch0.
    step(4'b1111, P_STRICT, 1'b1, 1'b0, 8'hE0, 4'b0100, 2'd3);
    step(4'b1111, P_STRICT, 1'b0, 1'b0, 8'hE0, 4'b0000, 2'd0);
    chk("pre_rst_valid", 32'(out_valid), 32'h1);
    reset_dut();
    step(4'b1111, P_TIE, 1'b1, 1'b0, 8'hF0, 4'b0001, 2'd2);
    step(4'b0000, P_TIE, 1'b1, 1'b0, 8'hF0, 4'b0000, 2'd0);
    step(4'b0000, P_TIE, 1'b1, 1'b0, 8'hF0, 4'b0000, 2'd0);
    chk("idle_out_valid", 32'(out_valid), 32'h0);
    chk("sb_drained", 32'(sb.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/priority_arb_mux.md
Name: priority_arb_mux

Overview:
Registered N-channel priority multiplexer with valid/ready handshakes on every input and on the output. Each cycle it picks the highest-priority valid channel, breaks ties round-robin, and can age starved channels up to maximum priority. It is the parametrised successor of our plain priority mux. It sits between multiple producers and a single downstream consumer, with one output register stage and full one-word-per-cycle throughput.

Parameters:
N_SIGNALS, 4, number of input channels (≥2)
N_SIGNAL_WIDTH, 8, data width per channel
N_PRIORITY_WIDTH, 2, priority field width; larger value = higher priority
AGE_WIDTH, 4, width of per-channel starvation counter
AGE_THRESHOLD, 15, wait cycles after which a channel is boosted (≤ 2^AGE_WIDTH-1)
SEL_WIDTH, $clog2(N_SIGNALS), derived; width of out_sel

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
mode  in  1  0 = strict priority, 1 = priority with aging
in_valid  in  N_SIGNALS  per-channel valid
in_data  in  N_SIGNALS*N_SIGNAL_WIDTH  channel i at bits [i*N_SIGNAL_WIDTH +: N_SIGNAL_WIDTH]
in_priority  in  N_SIGNALS*N_PRIORITY_WIDTH  channel i at [i*N_PRIORITY_WIDTH +: N_PRIORITY_WIDTH]
in_ready  out  N_SIGNALS  one-hot or zero; channel i accepted this cycle when in_valid[i] & in_ready[i]
out_valid  out  1  output register holds a word
out_data  out  N_SIGNAL_WIDTH  registered data
out_sel  out  SEL_WIDTH  index of the channel that supplied out_data
out_priority  out  N_PRIORITY_WIDTH  effective priority at grant time (boosted value if aged)
out_ready  in  1  consumer accepts when out_valid & out_ready

Behaviour:
- Reset (clk edge with rst=1): out_valid=0, out_data=0, out_sel=0, out_priority=0, all age counters=0, last_grant=N_SIGNALS-1, so the first tie goes to channel 0. in_ready is combinational and is 0 while rst=1.
- load_en = !out_valid | out_ready. No grant is issued unless load_en=1.
- Effective priority: eff[i] = in_priority[i]. If mode=1 and age[i]==AGE_THRESHOLD, eff[i] = all-ones.
- Pick: among channels with in_valid=1, choose max eff. Ties go to the first channel found searching from last_grant+1 upward with wrap-around.
- in_ready[i] = load_en & (i == pick) & any in_valid. This is combinational from in_valid, in_priority, out_ready, mode and state. There is no combinational path from in_data.
- On acceptance: out_data/out_sel/out_priority load next edge, out_valid=1, last_grant=pick. Latency is 1 cycle from accept to out_valid.
- Drain without a new accept (out_valid & out_ready & no valid input): out_valid→0. out_data holds its stale value.
- Drain plus accept in the same cycle: the register reloads and out_valid stays 1. Throughput is 1 word/cycle.
- Stall (out_valid & !out_ready): all outputs hold, in_ready=0.
- Age counters, per channel:
  - Cleared if in_valid[i]=0, or if channel i is accepted, or if mode=0.
  - Otherwise incremented, saturating at AGE_THRESHOLD.
  - Counters also advance during output stalls.
- Multiple aged channels: all have eff=max, so the round-robin tie-break resolves them.
- Producer rule: once in_valid[i]=1, data and priority are held until accepted. Priority changes while waiting are legal and take effect the same cycle.
- mode change takes effect on the current cycle's pick. Switching to 0 clears counters on the next edge.
- rst mid-transfer: the held output word is discarded and nothing is accepted in the rst cycle.

Decomposition:
- Package priority_mux_pkg holds:
  - typedef mode_e {MODE_STRICT=0, MODE_AGING=1}
  - function to compute effective priority
  - round-robin index helper
- Sub-module priority_pick (combinational): inputs are valid vector, eff vector and last_grant; outputs are pick index and any_valid. It is instantiated once.
- The top level holds the output register, last_grant and the age counters.

Test Plan:
- Strict pick: mode=0, valid=4'b1111, prio={ch3:1,ch2:3,ch1:2,ch0:0}, data=8'hA0+i, out_ready=1 → in_ready=4'b0100 on cycle 0. Next cycle out_data=8'hA2, out_sel=2, out_priority=3.
- Round-robin tie: all 4 valid, all prio=2, out_ready=1 held, with sources refilling → out_sel sequence 0,1,2,3,0 on consecutive cycles with no bubbles.
- Backpressure: out_valid=1 with out_ready=0 for 5 cycles → outputs stable and in_ready=0. Then raise out_ready → the word drains and the next grant loads on the same edge.
- Aging: mode=1, AGE_THRESHOLD=3, ch3 prio=3 continuously valid, ch0 prio=0 valid → ch0 is granted after waiting 3 cycles with out_priority=2'b11. Its age counter then clears. With mode=0 under the same stimulus, ch0 is never granted.
- Reset mid-operation: assert rst while out_valid=1 and out_ready=0 → next edge gives out_valid=0 and out_data=0. in_ready=0 during rst. The first post-reset tie goes to channel 0.
- Empty/idle: all in_valid=0 with out_ready=1 → out_valid falls 1 cycle after the last drain and in_ready=0.
